gcd_unit: RTL

- Sequential subtract-and-swap GCD engine that sits directly downstream of the 8-bit register-swap stage.
- Consumes one operand pair (a, b) per transaction over a valid/ready handshake.
- Iterates one compare/swap/subtract step per clock until the second operand is zero.
- Returns the result and an iteration count over a second valid/ready handshake.

---
 rtl/gcd_unit_if.sv | 25 ++
 rtl/gcd_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/gcd_unit_if.sv
// rtl/gcd_unit_if.sv - operand/result handshake bundle for gcd_unit
interface gcd_unit_if #(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 9
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a_in;
    logic [WIDTH-1:0]  b_in;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  gcd_out;
    logic [ITER_W-1:0] iter_out;
    logic              busy;

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, gcd_out, iter_out, busy
    );

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, gcd_out, iter_out, busy
    );
endinterface

// File: rtl/gcd_unit.sv
// rtl/gcd_unit.sv - sequential subtract-and-swap GCD engine with step counter
module gcd_unit #(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    gcd_unit_if.slave  gcd_if
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [ITER_W-1:0] CNT_MAX = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  w_a_nxt;
    logic [WIDTH-1:0]  w_b_nxt;
    logic [WIDTH-1:0]  r_gcd;
    logic [WIDTH-1:0]  w_gcd_nxt;
    logic [ITER_W-1:0] r_cnt;
    logic [ITER_W-1:0] w_cnt_nxt;
    logic [ITER_W-1:0] w_cnt_inc;
    logic [ITER_W-1:0] r_iter;
    logic [ITER_W-1:0] w_iter_nxt;
    logic              r_out_valid;
    logic              w_out_valid_nxt;

    // Saturate rather than wrap so a narrow counter still reports a lower bound.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + ITER_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_gcd       <= '0;
            r_iter      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gcd       <= w_gcd_nxt;
            r_iter      <= w_iter_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_cnt_nxt       = r_cnt;
        w_gcd_nxt       = r_gcd;
        w_iter_nxt      = r_iter;
        w_out_valid_nxt = r_out_valid;
        case (r_state)
            IDLE: begin
                if (gcd_if.in_valid) begin
                    w_a_nxt     = gcd_if.a_in;
                    w_b_nxt     = gcd_if.b_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_b == '0) begin
                    w_gcd_nxt       = r_a;
                    w_iter_nxt      = r_cnt;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = DONE;
                end else if (r_a < r_b) begin
                    w_a_nxt   = r_b;
                    w_b_nxt   = r_a;
                    w_cnt_nxt = w_cnt_inc;
                end else begin
                    w_a_nxt   = r_a - r_b;
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            DONE: begin
                if (gcd_if.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_out_valid_nxt = 1'b0;
                w_state_nxt     = IDLE;
            end
        endcase
    end

    assign gcd_if.in_ready  = (r_state == IDLE);
    assign gcd_if.busy      = (r_state == CALC);
    assign gcd_if.out_valid = r_out_valid;
    assign gcd_if.gcd_out   = r_gcd;
    assign gcd_if.iter_out  = r_iter;
endmodule
